flop_bist_checker: RTL
======================

FLOP_BIST_CHECKER -- requirements
Module: flop_bist_checker

Interface
REQ-001 SHALL have parameter PATTERN_LEN, default 16: number of pattern bits driven per run; legal range 1..255.
REQ-002 SHALL have parameter DUT_LATENCY, default 1: clock edges from dut_d change to dut_q reflecting it; legal range 1..8.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level-sampled run request; honoured only in IDLE.
REQ-006 SHALL have port dut_d  output  1  registered stimulus bit to the device under test (DUT).
REQ-007 SHALL have port dut_q  input  1  DUT response bit, synchronous to clk.
REQ-008 SHALL have port busy  output  1  high while in DRIVE or FLUSH.
REQ-009 SHALL have port done  output  1  high in DONE; held until the next accepted start or reset.
REQ-010 SHALL have port pass  output  1  equals done AND (err_count == 0).
REQ-011 SHALL have port err_count  output  8  number of mismatches in the current or last run; saturates at 255.

Function
REQ-012 SHALL implement states IDLE, DRIVE, FLUSH, DONE.
REQ-013 SHALL, when start=1 at edge E0 in IDLE or DONE, enter DRIVE, reload the LFSR with seed 8'hA5, clear err_count and done, and set dut_d to pattern bit 0.
REQ-014 SHALL present pattern bit i on dut_d from edge Ei to E(i+1), for i = 0..PATTERN_LEN-1.
REQ-015 SHALL generate pattern bits with an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1; output bit = lfsr[0]; LFSR advances once per DRIVE edge.
REQ-016 SHALL enter FLUSH at edge E(PATTERN_LEN) and hold dut_d at 0 from that edge onward.
REQ-017 SHALL delay each driven bit and a valid flag through an internal line of depth DUT_LATENCY+1; expected bit i is compared against dut_q at edge E(i+DUT_LATENCY+1).
REQ-018 SHALL increment err_count by one on each valid compare where dut_q != expected; no increment when the value is 255.
REQ-019 SHALL enter DONE at the edge performing the last compare, E(PATTERN_LEN+DUT_LATENCY), with err_count already including that compare.
REQ-020 SHALL ignore start while busy=1; the run continues unchanged.
REQ-021 SHALL, in DONE with start=0, hold done, pass and err_count stable indefinitely.
REQ-022 SHALL ignore dut_q in IDLE and DONE, and whenever the delay-line valid flag is 0.
REQ-023 SHALL keep busy and done mutually exclusive in every cycle.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE; dut_d, busy, done, pass = 0; err_count = 0; LFSR = 8'hA5; delay line and valid flags cleared.
REQ-025 SHALL, on reset asserted mid-run, abandon the run entirely; after release, no compare result from the abandoned run affects err_count.
REQ-026 SHALL require a fresh start after reset release; there is no auto-restart.

Structure
REQ-027 SHALL place the state enumeration, LFSR seed (8'hA5), LFSR tap mask and err_count width in the shared package flop_bist_pkg.
REQ-028 SHALL use one sub-module, lfsr8, with ports clk, rst_n, load, advance, bit_out; the FSM, delay line and error counter stay in flop_bist_checker.

Verification
REQ-029 SHALL check loopback (dut_q = dut_d registered once, DUT_LATENCY=1, PATTERN_LEN=16), start pulsed one cycle: busy=1 for edges E0..E16, done=1 after E17, err_count=0, pass=1.
REQ-030 SHALL check the inverting DUT (dut_q = ~dut_d registered), same parameters: done after E17, err_count=16, pass=0.
REQ-031 SHALL check single-bit corruption, with loopback output inverted for exactly one compare cycle: err_count=1, pass=0.
REQ-032 SHALL check latency mismatch (two-flop DUT, DUT_LATENCY=2, PATTERN_LEN=16): err_count=0, done after E18; the same DUT with DUT_LATENCY=1 gives err_count>0.
REQ-033 SHALL check reset mid-run (rst_n low at E5 during DRIVE): all outputs 0 immediately; after release and a new start with loopback, err_count=0, pass=1.
REQ-034 SHALL check start held high throughout a loopback run: no restart during busy; a second run begins at the edge after DONE is entered, clearing done and err_count.

Source files
------------

// File: rtl/flop_bist_pkg.sv
// Shared definitions for the flop BIST checker: FSM states, LFSR constants
// and the error counter width.
package flop_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Pattern generator seed, reloaded at the start of every run.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in a right-shifting register
  // whose output is bit 0: bits 0, 2, 3 and 4 feed the new bit 7.
  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  localparam int                ERR_W   = 8;
  localparam logic [ERR_W-1:0]  ERR_MAX = '1;

  // One Fibonacci step: shift right, parity of the tapped bits enters at the top.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {^(cur & LFSR_TAPS), cur[7:1]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR pattern source. bit_out is the value bit 0 of the
// register takes after the current edge, so the owner can register it in
// the same cycle the LFSR is loaded or advanced.
module lfsr8
  import flop_bist_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic bit_out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next register value: reload wins over advance, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // LFSR register, seeded during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_d[0];

endmodule

// File: rtl/flop_bist_checker.sv
// Drives an LFSR pattern into a registered device, delays the expected bits
// to line up with the device response and counts mismatches.
// start is a level: it is taken in IDLE or DONE and ignored while busy.
// The internal compare line is DUT_LATENCY+1 deep; stage 0 mirrors dut_d,
// so the last stage holds the bit that dut_q must carry at this edge.
module flop_bist_checker
  import flop_bist_pkg::*;
#(
  parameter int PATTERN_LEN = 16,
  parameter int DUT_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int         DEPTH    = DUT_LATENCY + 1;
  localparam logic [7:0] LAST_BIT = 8'(PATTERN_LEN - 1);

  bist_state_e      state_q, state_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic             dut_d_q, dut_d_d;
  logic             drive_vld;
  logic [DEPTH-1:0] exp_q, exp_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             lfsr_load, lfsr_adv, lfsr_bit;
  logic             run_active, accept, cmp_en, last_cmp, mismatch;

  assign run_active = (state_q == ST_DRIVE) || (state_q == ST_FLUSH);
  assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign lfsr_load  = accept;
  assign lfsr_adv   = (state_q == ST_DRIVE);

  // A compare happens when a valid expected bit reaches the end of the line;
  // the final one is recognised by the invalid bit queued right behind it.
  assign cmp_en   = run_active && vld_q[DEPTH-1];
  assign last_cmp = cmp_en && !vld_q[DEPTH-2];
  assign mismatch = cmp_en && (dut_q != exp_q[DEPTH-1]);

  lfsr8 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .bit_out (lfsr_bit)
  );

  // FSM next state, stimulus bit selection and bit counter.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dut_d_d   = 1'b0;
    drive_vld = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          bit_cnt_d = 8'd0;
          dut_d_d   = lfsr_bit;
          drive_vld = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_FLUSH;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          dut_d_d   = lfsr_bit;
          drive_vld = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_FLUSH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (last_cmp) begin
      state_d = ST_DONE;
    end
  end

  // Expected-bit line and saturating error counter.
  always_comb begin
    exp_d = {exp_q[DEPTH-2:0], dut_d_d};
    vld_d = {vld_q[DEPTH-2:0], drive_vld};
    err_d = err_q;
    if (accept) begin
      err_d = '0;
    end else if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  // State, stimulus, compare line and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 8'd0;
      dut_d_q   <= 1'b0;
      exp_q     <= '0;
      vld_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dut_d_q   <= dut_d_d;
      exp_q     <= exp_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign dut_d     = dut_d_q;
  assign busy      = run_active;
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

endmodule
